// File: rtl/uart_rx_string_pkg.sv
// Shared definitions for the UART string receiver: timing derivations and
// the receive-core state encoding.
package uart_rx_string_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit period, truncated.
  function automatic int calc_bit_cnt(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Clocks from the start-bit edge to the middle of the start bit.
  function automatic int calc_half_cnt(input int bit_cnt);
    return bit_cnt / 2;
  endfunction

  // Clocks of inter-byte silence tolerated while a partial match is pending.
  function automatic int calc_to_max(input int clk_freq, input int timeout_ms);
    return (clk_freq / 1000) * timeout_ms;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART deserialiser: two-flop synchroniser, start-bit qualification at
// mid-bit, centre sampling of data and stop bits.
module uart_rx_core
  import uart_rx_string_pkg::*;
#(
  parameter int CLK_FREQ  = 10_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] dout,
  output logic       dat_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CNT = calc_half_cnt(BIT_CNT);
  localparam int CNT_W    = $clog2(BIT_CNT);

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_CNT - 1);

  logic [1:0]       r_sync;
  logic             r_sync_d;
  logic             w_line;
  logic             w_fall;

  rx_state_t        r_state,   w_state_next;
  logic [CNT_W-1:0] r_cnt,     w_cnt_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next;
  logic [7:0]       r_shift,   w_shift_next;
  logic [7:0]       r_dout,    w_dout_next;
  logic             r_valid,   w_valid_next;
  logic             r_ferr,    w_ferr_next;

  // Bring the asynchronous line into the clock domain; keep one extra sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_sync_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[0], uart_rxd};
      r_sync_d <= r_sync[1];
    end
  end

  assign w_line = r_sync[1];
  assign w_fall = r_sync_d & ~r_sync[1];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_dout    <= w_dout_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
    end
  end

  // Next-state and datapath decisions; pulses default low every cycle.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_dout_next    = r_dout;
    w_valid_next   = 1'b0;
    w_ferr_next    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_next = START;
          w_cnt_next   = '0;
        end
      end

      START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_next = '0;
          if (w_line) begin
            // Line recovered before mid-bit: a glitch, not a start bit.
            w_state_next = IDLE;
          end else begin
            w_state_next   = DATA;
            w_bit_idx_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {w_line, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          w_cnt_next   = '0;
          w_state_next = IDLE;
          if (w_line) begin
            w_dout_next  = r_shift;
            w_valid_next = 1'b1;
          end else begin
            w_ferr_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign dout      = r_dout;
  assign dat_valid = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy   = (r_state != IDLE);

endmodule

// File: rtl/uart_rx_string.sv
// UART receiver with a fixed-string detector: exposes every received byte
// and pulses match when the whole command string arrives within the
// inter-byte timeout.
module uart_rx_string
  import uart_rx_string_pkg::*;
#(
  parameter int                     CLK_FREQ   = 10_000_000,
  parameter int                     BAUD_RATE  = 115_200,
  parameter int                     STR_LEN    = 5,
  parameter logic [8*STR_LEN-1:0]   STR_DAT    = "TEST\r",
  parameter int                     TIMEOUT_MS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       match
);

  localparam int TO_MAX = calc_to_max(CLK_FREQ, TIMEOUT_MS);
  localparam int IDX_W  = $clog2(STR_LEN);
  localparam int GAP_W  = $clog2(TO_MAX);

  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(STR_LEN - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(TO_MAX - 1);

  logic [7:0]       w_dout;
  logic             w_valid;
  logic             w_ferr;
  logic             w_rx_busy;
  logic             w_unused_busy;

  logic [7:0]       w_str [STR_LEN];
  logic [7:0]       w_exp;

  logic [IDX_W-1:0] r_idx;
  logic [GAP_W-1:0] r_gap;
  logic             r_match;

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .dout      (w_dout),
    .dat_valid (w_valid),
    .frame_err (w_ferr),
    .rx_busy   (w_rx_busy)
  );

  // Busy is only of interest when probing the core; the matcher does not need it.
  assign w_unused_busy = w_rx_busy;

  // Split the string into a byte table; entry 0 is the first character sent.
  generate
    for (genvar gi = 0; gi < STR_LEN; gi++) begin : g_str
      assign w_str[gi] = STR_DAT[(STR_LEN - gi) * 8 - 1 -: 8];
    end
  endgenerate

  assign w_exp = w_str[r_idx];

  // Match index, inter-byte gap timer and the match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_gap   <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (w_valid) begin
        // A fresh byte always restarts the gap timer, even on the timeout cycle.
        r_gap <= '0;
        if (w_dout == w_exp) begin
          if (r_idx == C_IDX_LAST) begin
            r_match <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end else if (w_dout == w_str[0]) begin
          // Only the single-character restart is recognised, not general overlap.
          r_idx <= C_IDX_ONE;
        end else begin
          r_idx <= '0;
        end
      end else if (w_ferr) begin
        r_idx <= '0;
        r_gap <= '0;
      end else if (r_idx != '0) begin
        if (r_gap == C_GAP_LAST) begin
          r_idx <= '0;
          r_gap <= '0;
        end else begin
          r_gap <= r_gap + 1'b1;
        end
      end else begin
        r_gap <= '0;
      end
    end
  end

  assign rx_data   = w_dout;
  assign rx_valid  = w_valid;
  assign frame_err = w_ferr;
  assign match     = r_match;

endmodule
